// File: rtl/dp_line_framer_four_channels_if.sv
`default_nettype none
// ============================================================================
//  Module   : dp_line_framer_four_channels_if
//  Purpose  : Packed-pixel stream into the four-lane line framer.
//             One 64-bit word carries 8 pixel bytes, 2 per lane.
//  Signals  : pixel_data  [63:0]  packed pixel word (producer -> framer)
//             pixel_valid         pixel_data is valid (producer -> framer)
//             pixel_ready         framer consumes pixel_data this cycle
//  Modports : master = pixel producer, slave = framer
//  Revision : 1.0  initial release
// ============================================================================
interface dp_line_framer_four_channels_if;
    logic [63:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;

    modport master (
        output pixel_data,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_data,
        input  pixel_valid,
        output pixel_ready
    );
endinterface
`default_nettype wire

// File: rtl/dp_line_framer_four_channels.sv
`default_nettype none
// ============================================================================
//  Module   : dp_line_framer_four_channels
//  Purpose  : Per-line symbol framing for the four-lane test stream. Emits
//             BS, VB-ID, Mvid, Maud, BE and dummy blanking symbols and packs
//             pixel words into the active region of each line. Output goes
//             straight to the MSA inserter.
//  Ports    : clk          link-side symbol clock
//             rst          synchronous active-high reset
//             enable       video enable, sampled only at line 0 / cycle 0
//             interlaced   VB-ID bit 2
//             field_odd    VB-ID bit 1
//             M_value      [7:0] transmitted as Mvid
//             pix          pixel stream (slave modport)
//             underflow    sticky: ready offered while valid was low
//             out_data     {line_start, lane3, lane2, lane1, lane0}, each
//                          lane {data1[8:0], data0[8:0]}, bit 8 = K flag
//  Revision : 1.0  initial release
// ============================================================================
module dp_line_framer_four_channels #(
    parameter int H_TOTAL   = 396,
    parameter int H_BLANK   = 96,
    parameter int V_VISIBLE = 600,
    parameter int V_TOTAL   = 628
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           enable,
    input  wire logic                           interlaced,
    input  wire logic                           field_odd,
    input  wire logic [23:0]                    M_value,
    dp_line_framer_four_channels_if.slave       pix,
    output      logic                           underflow,
    output      logic [72:0]                    out_data
);

    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] c_h_last  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_blank = HW'(H_BLANK);
    localparam logic [HW-1:0] c_h_be    = HW'(H_BLANK - 1);
    localparam logic [VW-1:0] c_v_last  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_vis   = VW'(V_VISIBLE);

    localparam logic [8:0] c_sym_bs    = 9'b110111100;   // K28.5
    localparam logic [8:0] c_sym_be    = 9'b111111011;   // K27.7
    localparam logic [8:0] c_sym_dummy = 9'b000000000;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_video_en;
    logic          r_underflow;
    logic [72:0]   r_out_data;

    logic          w_at_origin;
    logic          w_video_en;
    logic          w_vb;
    logic [8:0]    w_vbid;
    logic [8:0]    w_mvid;
    logic [8:0]    w_maud;
    logic          w_ready;
    logic [8:0]    w_sym0;
    logic [8:0]    w_sym1;
    logic          w_line_start;
    logic          w_pix_sel;
    logic [72:0]   w_next_out;
    logic          w_unused;

    // Only the low byte of M_value is transmitted.
    assign w_unused = ^M_value[23:8];

    // At (0,0) the framing symbols of the first cycle must already reflect
    // the enable being loaded on that same edge, so the effective video
    // enable bypasses the register there.
    always_comb begin
        w_at_origin = (r_h == '0) && (r_v == '0);
        w_video_en  = w_at_origin ? enable : r_video_en;
        w_vb        = (r_v >= c_v_vis);
        w_vbid      = {1'b0, 4'b0000, ~w_video_en, interlaced, field_odd, w_vb};
        w_mvid      = {1'b0, M_value[7:0]};
        w_maud      = 9'h000;
        w_ready     = (r_h >= c_h_blank) && !w_vb && r_video_en;
    end

    // Symbol selection common to all four lanes.
    always_comb begin
        w_sym0       = c_sym_dummy;
        w_sym1       = c_sym_dummy;
        w_line_start = 1'b0;
        w_pix_sel    = 1'b0;
        if (r_h == HW'(0)) begin
            w_sym0       = c_sym_bs;
            w_sym1       = w_vbid;
            w_line_start = 1'b1;
        end else if (r_h == HW'(1)) begin
            w_sym0 = w_mvid;
            w_sym1 = w_maud;
        end else if (r_h == HW'(2)) begin
            w_sym0 = w_vbid;
            w_sym1 = w_mvid;
        end else if (r_h == HW'(3)) begin
            w_sym0 = w_maud;
            w_sym1 = c_sym_dummy;
        end else if (r_h == c_h_be) begin
            w_sym1 = (!w_vb && w_video_en) ? c_sym_be : c_sym_dummy;
        end else if (w_ready) begin
            // A ready cycle without valid data falls back to dummies.
            w_pix_sel = pix.pixel_valid;
        end
    end

    generate
        for (genvar L = 0; L < 4; L++) begin : g_lane
            assign w_next_out[18*L +: 18] = w_pix_sel
                ? {1'b0, pix.pixel_data[16*L+8 +: 8], 1'b0, pix.pixel_data[16*L +: 8]}
                : {w_sym1, w_sym0};
        end
    endgenerate

    assign w_next_out[72] = w_line_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h         <= '0;
            r_v         <= '0;
            r_video_en  <= 1'b0;
            r_underflow <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (r_h == c_h_last) begin
                r_h <= '0;
                r_v <= (r_v == c_v_last) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
            if (w_at_origin) begin
                r_video_en <= enable;
            end
            if (w_ready && !pix.pixel_valid) begin
                r_underflow <= 1'b1;
            end
            r_out_data <= w_next_out;
        end
    end

    assign pix.pixel_ready = w_ready;
    assign underflow       = r_underflow;
    assign out_data        = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_dp_line_framer_four_channels.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_line_framer_four_channels
//  Purpose  : Directed self-checking bench for the four-lane line framer
//             using a 16x5 line/frame geometry (6 blanking cycles, 3 active
//             lines).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_line_framer_four_channels;

    localparam logic [8:0] BS = 9'h1BC;
    localparam logic [8:0] BE = 9'h1FB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        interlaced = 1'b0;
    logic        field_odd = 1'b0;
    logic [23:0] M_value = 24'h123456;
    logic        underflow;
    logic [72:0] out_data;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;   // index of the cycle currently being presented

    dp_line_framer_four_channels_if pif ();

    dp_line_framer_four_channels #(
        .H_TOTAL   (16),
        .H_BLANK   (6),
        .V_VISIBLE (3),
        .V_TOTAL   (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .interlaced (interlaced),
        .field_odd  (field_odd),
        .M_value    (M_value),
        .pix        (pif),
        .underflow  (underflow),
        .out_data   (out_data)
    );

    initial forever #5 clk = ~clk;

    // Pixel word for cycle n: byte k = n + k (distinct bytes expose lane swaps).
    function automatic logic [63:0] pix(input int n);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(n + k);
        return w;
    endfunction

    function automatic logic [72:0] exp_pix(input int n);
        logic [63:0] w;
        logic [72:0] e;
        w = pix(n);
        e = '0;
        for (int l = 0; l < 4; l++)
            e[18*l +: 18] = {1'b0, w[16*l+8 +: 8], 1'b0, w[16*l +: 8]};
        return e;
    endfunction

    // Blanking-region output for cycle h with Mvid = 0x56.
    function automatic logic [72:0] exp_blank(input int h, input logic [7:0] vbid, input logic be_on);
        logic [8:0] s0;
        logic [8:0] s1;
        logic       ls;
        s0 = 9'h000; s1 = 9'h000; ls = 1'b0;
        case (h)
            0: begin s0 = BS; s1 = {1'b0, vbid}; ls = 1'b1; end
            1: begin s0 = 9'h056; s1 = 9'h000; end
            2: begin s0 = {1'b0, vbid}; s1 = 9'h056; end
            5: s1 = be_on ? BE : 9'h000;
            default: ;
        endcase
        return {ls, {4{s1, s0}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        pif.pixel_data = pix(cyc);
    endtask

    task automatic reset_dut(input logic en);
        rst = 1'b1;
        enable = en;
        pif.pixel_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        pif.pixel_data = pix(0);
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        pif.pixel_valid = 1'b1;
        pif.pixel_data = pix(0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_data !== 73'b0) $display("FAIL reset_out: got %h expected %h", out_data, 73'b0); else passed++;
        checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else passed++;
        checks++; if (pif.pixel_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", pif.pixel_ready); else passed++;
        rst = 1'b0;
        cyc = 0;
        pif.pixel_data = pix(0);
    endtask

    task automatic test_active_line();
        logic [72:0] e;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (pif.pixel_ready !== (i >= 6))
                $display("FAIL line0_ready h=%0d: got %b expected %b", i, pif.pixel_ready, (i >= 6));
            else passed++;
            tick();
            e = (i < 6) ? exp_blank(i, 8'h00, 1'b1) : exp_pix(i);
            checks++;
            if (out_data !== e) $display("FAIL line0_out h=%0d: got %h expected %h", i, out_data, e);
            else passed++;
        end
    endtask

    task automatic test_vblank_line();
        logic [72:0] e;
        advance_to(48);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (pif.pixel_ready !== 1'b0)
                $display("FAIL vblank_ready h=%0d: got %b expected 0", i, pif.pixel_ready);
            else passed++;
            tick();
            e = exp_blank(i, 8'h01, 1'b0);
            checks++;
            if (out_data !== e) $display("FAIL vblank_out h=%0d: got %h expected %h", i, out_data, e);
            else passed++;
        end
    endtask

    task automatic test_enable_late();
        logic [72:0] e;
        reset_dut(1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            e = exp_blank(i, 8'h08, 1'b0);
            checks++;
            if (out_data !== e) $display("FAIL disabled_out h=%0d: got %h expected %h", i, out_data, e);
            else passed++;
        end
        advance_to(16);
        enable = 1'b1;
        tick();
        e = exp_blank(0, 8'h08, 1'b0);
        checks++; if (out_data !== e) $display("FAIL late_line1_h0: got %h expected %h", out_data, e); else passed++;
        advance_to(22);
        checks++; if (pif.pixel_ready !== 1'b0) $display("FAIL late_line1_ready: got %b expected 0", pif.pixel_ready); else passed++;
        advance_to(80);
        for (int i = 0; i < 7; i++) begin
            tick();
            e = (i < 6) ? exp_blank(i, 8'h00, 1'b1) : exp_pix(86);
            checks++;
            if (out_data !== e) $display("FAIL frame1_out h=%0d: got %h expected %h", i, out_data, e);
            else passed++;
        end
        checks++; if (pif.pixel_ready !== 1'b1) $display("FAIL frame1_ready: got %b expected 1", pif.pixel_ready); else passed++;
    endtask

    task automatic test_interlace();
        logic [72:0] e;
        interlaced = 1'b1;
        field_odd  = 1'b1;
        reset_dut(1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_blank(i, 8'h06, 1'b1);
            checks++;
            if (out_data !== e) $display("FAIL interlace_active h=%0d: got %h expected %h", i, out_data, e);
            else passed++;
        end
        advance_to(48);
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_blank(i, 8'h07, 1'b0);
            checks++;
            if (out_data !== e) $display("FAIL interlace_vblank h=%0d: got %h expected %h", i, out_data, e);
            else passed++;
        end
        interlaced = 1'b0;
        field_odd  = 1'b0;
    endtask

    task automatic test_underflow();
        logic [72:0] e;
        reset_dut(1'b1);
        advance_to(25);
        checks++; if (underflow !== 1'b0) $display("FAIL underflow_pre: got %b expected 0", underflow); else passed++;
        pif.pixel_valid = 1'b0;
        tick();
        checks++; if (out_data !== 73'b0) $display("FAIL underflow_out: got %h expected %h", out_data, 73'b0); else passed++;
        checks++; if (underflow !== 1'b1) $display("FAIL underflow_set: got %b expected 1", underflow); else passed++;
        pif.pixel_valid = 1'b1;
        tick();
        e = exp_pix(26);
        checks++; if (out_data !== e) $display("FAIL underflow_resume: got %h expected %h", out_data, e); else passed++;
        advance_to(27 + 160);
        checks++; if (underflow !== 1'b1) $display("FAIL underflow_sticky: got %b expected 1", underflow); else passed++;
    endtask

    task automatic test_mid_reset();
        logic [72:0] e;
        reset_dut(1'b1);
        advance_to(7);
        pif.pixel_valid = 1'b0;
        tick();
        pif.pixel_valid = 1'b1;
        checks++; if (underflow !== 1'b1) $display("FAIL midreset_pre_underflow: got %b expected 1", underflow); else passed++;
        advance_to(40);
        rst = 1'b1;
        tick();
        checks++; if (out_data !== 73'b0) $display("FAIL midreset_out: got %h expected %h", out_data, 73'b0); else passed++;
        checks++; if (underflow !== 1'b0) $display("FAIL midreset_underflow: got %b expected 0", underflow); else passed++;
        rst = 1'b0;
        cyc = 0;
        pif.pixel_data = pix(0);
        checks++; if (pif.pixel_ready !== 1'b0) $display("FAIL midreset_ready_h0: got %b expected 0", pif.pixel_ready); else passed++;
        tick();
        e = exp_blank(0, 8'h00, 1'b1);
        checks++; if (out_data !== e) $display("FAIL midreset_h0: got %h expected %h", out_data, e); else passed++;
        tick();
        e = exp_blank(1, 8'h00, 1'b1);
        checks++; if (out_data !== e) $display("FAIL midreset_h1: got %h expected %h", out_data, e); else passed++;
        advance_to(6);
        checks++; if (pif.pixel_ready !== 1'b1) $display("FAIL midreset_ready_h6: got %b expected 1", pif.pixel_ready); else passed++;
    endtask

    initial begin
        pif.pixel_valid = 1'b1;
        pif.pixel_data  = '0;
        test_reset();
        test_active_line();
        test_vblank_line();
        test_enable_late();
        test_interlace();
        test_underflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
